// File: rtl/config_loader.sv
// config_loader: serial bitstream front-end for the tile array.
// Assembles start/address/data/parity frames and commits them to the config bus.
module config_loader #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 88
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bit_in,
    input  logic              bit_valid,
    input  logic              clear_err,
    output logic              config_en,
    output logic [ADDR_W-1:0] config_addr,
    output logic [0:DATA_W-1] config_data,
    output logic              busy,
    output logic              frame_err,
    output logic [7:0]        frames_loaded
);

    localparam int CNT_W = 7;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ADDR   = 2'd1;
    localparam logic [1:0] S_DATA   = 2'd2;
    localparam logic [1:0] S_PARITY = 2'd3;

    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

    logic [1:0]        state_q,  state_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;
    logic [ADDR_W-1:0] ash_q,    ash_d;
    logic [0:DATA_W-1] dsh_q,    dsh_d;
    logic              par_q,    par_d;
    logic              en_q,     en_d;
    logic [ADDR_W-1:0] addr_q,   addr_d;
    logic [0:DATA_W-1] data_q,   data_d;
    logic              err_q,    err_d;
    logic [7:0]        frames_q, frames_d;

    // Frame FSM: shift bits into shadows, commit on matching parity.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ash_d    = ash_q;
        dsh_d    = dsh_q;
        par_d    = par_q;
        en_d     = 1'b0;
        addr_d   = addr_q;
        data_d   = data_q;
        err_d    = err_q & ~clear_err;
        frames_d = frames_q;
        if (bit_valid) begin
            unique case (state_q)
                S_IDLE: begin
                    if (bit_in) begin
                        state_d = S_ADDR;
                        cnt_d   = '0;
                        par_d   = 1'b0;
                    end
                end
                S_ADDR: begin
                    ash_d = {ash_q[ADDR_W-2:0], bit_in};
                    par_d = par_q ^ bit_in;
                    if (cnt_q == ADDR_LAST) begin
                        state_d = S_DATA;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 7'd1;
                    end
                end
                S_DATA: begin
                    dsh_d[cnt_q] = bit_in;
                    par_d        = par_q ^ bit_in;
                    if (cnt_q == DATA_LAST) begin
                        state_d = S_PARITY;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 7'd1;
                    end
                end
                S_PARITY: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    if (bit_in == par_q) begin
                        en_d     = 1'b1;
                        addr_d   = ash_q;
                        data_d   = dsh_q;
                        frames_d = frames_q + 8'd1;
                    end else begin
                        // A failing frame wins over a same-cycle clear.
                        err_d = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            ash_q    <= '0;
            dsh_q    <= '0;
            par_q    <= 1'b0;
            en_q     <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            err_q    <= 1'b0;
            frames_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ash_q    <= ash_d;
            dsh_q    <= dsh_d;
            par_q    <= par_d;
            en_q     <= en_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            err_q    <= err_d;
            frames_q <= frames_d;
        end
    end

    assign config_en     = en_q;
    assign config_addr   = addr_q;
    assign config_data   = data_q;
    assign busy          = (state_q != S_IDLE);
    assign frame_err     = err_q;
    assign frames_loaded = frames_q;

endmodule

// File: tb/tb_config_loader.sv
// tb_config_loader: directed and randomized frames against a
// frame-level model of the config bus (last commit, count, error flag).
module tb_config_loader;

    localparam int AW = 6;
    localparam int DW = 88;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          bit_in = 1'b0;
    logic          bit_valid = 1'b0;
    logic          clear_err = 1'b0;
    logic          config_en;
    logic [AW-1:0] config_addr;
    logic [0:DW-1] config_data;
    logic          busy;
    logic          frame_err;
    logic [7:0]    frames_loaded;

    config_loader #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bit_in        (bit_in),
        .bit_valid     (bit_valid),
        .clear_err     (clear_err),
        .config_en     (config_en),
        .config_addr   (config_addr),
        .config_data   (config_data),
        .busy          (busy),
        .frame_err     (frame_err),
        .frames_loaded (frames_loaded)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Frame-level reference model state.
    logic [AW-1:0] exp_addr = '0;
    logic [0:DW-1] exp_data = '0;
    int            exp_frames = 0;
    logic          exp_err = 1'b0;

    // Strobe monitor: counts commits and checks the strobe is one cycle wide.
    int            strobes = 0;
    logic [AW-1:0] last_addr = '0;
    logic          prev_en = 1'b0;

    always @(negedge clk) begin
        if (config_en === 1'b1) begin
            strobes++;
            last_addr = config_addr;
            checks++;
            assert (prev_en === 1'b0) else begin
                failures++;
                $error("FAIL en_width observed=%b expected=0", prev_en);
            end
        end
        prev_en = config_en;
    end

    task automatic check(input string tag, input logic [127:0] obs,
                         input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [0:DW-1] rnd_data();
        logic [95:0] t;
        t = {$urandom, $urandom, $urandom};
        return t[DW-1:0];
    endfunction

    task automatic do_reset();
        rst_n     = 1'b0;
        bit_valid = 1'b0;
        clear_err = 1'b0;
        repeat (2) @(negedge clk);
        rst_n      = 1'b1;
        exp_addr   = '0;
        exp_data   = '0;
        exp_frames = 0;
        exp_err    = 1'b0;
    endtask

    // Sends one frame starting at the current negedge; returns at the
    // negedge following the parity edge, i.e. inside the strobe cycle.
    task automatic send_frame(input logic [AW-1:0] a, input logic [0:DW-1] d,
                              input bit bad, input bit stall,
                              input bit clr_last);
        logic fb[96];
        fb[0] = 1'b1;
        for (int i = 0; i < AW; i++) fb[1+i] = a[AW-1-i];
        for (int i = 0; i < DW; i++) fb[1+AW+i] = d[i];
        fb[95] = (^a) ^ (^d) ^ bad;
        for (int i = 0; i < 96; i++) begin
            if (stall && i > 0) begin
                for (int s = 0; s < 4 && $urandom_range(0, 1) == 1; s++) begin
                    bit_valid = 1'b0;
                    bit_in    = 1'($urandom);
                    @(negedge clk);
                end
            end
            bit_valid = 1'b1;
            bit_in    = fb[i];
            clear_err = clr_last && (i == 95);
            @(negedge clk);
            if (i == 0)  check("busy_start", 128'(busy), 128'(1'b1));
            if (i == 50) check("addr_hold", 128'(config_addr), 128'(exp_addr));
        end
        bit_valid = 1'b0;
        clear_err = 1'b0;
        if (!bad) begin
            exp_addr   = a;
            exp_data   = d;
            exp_frames = (exp_frames + 1) % 256;
            if (clr_last) exp_err = 1'b0;
        end else begin
            exp_err = 1'b1;
        end
        check("en", 128'(config_en), 128'(!bad));
        check("addr", 128'(config_addr), 128'(exp_addr));
        check("data", 128'(config_data), 128'(exp_data));
        check("frames", 128'(frames_loaded), 128'(exp_frames));
        check("err", 128'(frame_err), 128'(exp_err));
        check("busy_end", 128'(busy), 128'(1'b0));
    endtask

    initial begin
        int s0;
        logic [0:DW-1] d;

        // Reset then idle filler.
        do_reset();
        bit_valid = 1'b1;
        bit_in    = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_ctl",
                  128'({busy, config_en, frame_err, frames_loaded, config_addr}),
                  128'(0));
            if (i % 5 == 0) check("idle_data", 128'(config_data), 128'(0));
        end
        bit_valid = 1'b0;

        // Single good frame.
        d = '0;
        d[0] = 1'b1; d[81] = 1'b1; d[87] = 1'b1;
        s0 = strobes;
        send_frame(6'd5, d, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("en_drop", 128'(config_en), 128'(0));
        check("strobe1", 128'(strobes - s0), 128'(1));

        // Bad parity, sticky error, clear, then clear racing a failure.
        s0 = strobes;
        send_frame(6'd5, d, 1'b1, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        check("err_sticky", 128'(frame_err), 128'(1'b1));
        check("bad_nostrobe", 128'(strobes - s0), 128'(0));
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        exp_err   = 1'b0;
        check("err_clr", 128'(frame_err), 128'(exp_err));
        send_frame(6'd20, rnd_data(), 1'b1, 1'b0, 1'b1);
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        exp_err   = 1'b0;

        // Stalls and back-to-back frames.
        s0 = strobes;
        send_frame(6'd1, rnd_data(), 1'b0, 1'b1, 1'b0);
        send_frame(6'd63, '1, 1'b0, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        check("b2b_strobes", 128'(strobes - s0), 128'(2));
        check("b2b_last", 128'(last_addr), 128'(6'd63));

        // Reset in the middle of a frame.
        bit_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            bit_in = (i == 0) ? 1'b1 : 1'($urandom);
            @(negedge clk);
        end
        s0 = strobes;
        do_reset();
        check("rst_frames", 128'(frames_loaded), 128'(0));
        send_frame(6'd9, rnd_data(), 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check("rst_strobes", 128'(strobes - s0), 128'(1));
        check("rst_addr", 128'(last_addr), 128'(6'd9));

        // Counter wrap over 256 frames.
        do_reset();
        s0 = strobes;
        for (int f = 0; f < 256; f++)
            send_frame(6'($urandom), rnd_data(), 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check("wrap_frames", 128'(frames_loaded), 128'(0));
        check("wrap_strobes", 128'(strobes - s0), 128'(256));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
